// File: rtl/sevenseg_scan.sv
// Time-multiplexed N-digit seven-segment driver: a prescaler scans the digits, a shadow value
// is swapped in only at frame boundaries. Define SEVENSEG_SCAN_LZB_EN for leading-zero blanking.
module sevenseg_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] in_value,
  input  logic [NUM_DIGITS-1:0]   in_dp,
  input  logic                    in_load,
  output logic [6:0]              out_seg,
  output logic                    out_dp,
  output logic [NUM_DIGITS-1:0]   out_an,
  output logic                    out_frame
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VAL_W = 4 * NUM_DIGITS;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W:0]   BLANK_LIM = (CNT_W + 1)'(BLANK_CYCLES);
  localparam logic             POL       = (ACTIVE_LOW != 0);

  function automatic logic [6:0] font(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] seg_pol(input logic [6:0] lit);
    return POL ? ~lit : lit;
  endfunction

  logic [CNT_W-1:0]      cnt_p0;
  logic [IDX_W-1:0]      idx_p0;
  logic [VAL_W-1:0]      shadow_val, pend_val;
  logic [NUM_DIGITS-1:0] shadow_dp, pend_dp;
  logic                  pend_flag;

  logic                  slot_end, boundary, blank_p0;
  logic [3:0]            nib_p0;
  logic                  dp_bit_p0;
  logic [NUM_DIGITS-1:0] an_hot_p0;
  logic [6:0]            lit_p0;

  logic [6:0]            seg_p1;
  logic                  dp_p1, frame_p1;
  logic [NUM_DIGITS-1:0] an_p1;

  assign slot_end = (cnt_p0 == CNT_LAST);
  assign boundary = slot_end && (idx_p0 == IDX_LAST);
  assign blank_p0 = ({1'b0, cnt_p0} < BLANK_LIM);

  always_comb begin
    nib_p0    = 4'h0;
    dp_bit_p0 = 1'b0;
    an_hot_p0 = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_p0 == IDX_W'(k)) begin
        nib_p0       = shadow_val[4*k +: 4];
        dp_bit_p0    = shadow_dp[k];
        an_hot_p0[k] = 1'b1;
      end
    end
  end

`ifdef SEVENSEG_SCAN_LZB_EN
  // lz[k] is set while every digit from the top down to k is a bare zero; digit 0 never qualifies.
  logic [NUM_DIGITS-1:0] lz;
  logic                  run;
  always_comb begin
    lz  = '0;
    run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      run   = run && (shadow_val[4*k +: 4] == 4'h0) && !shadow_dp[k];
      lz[k] = run;
    end
  end
  assign lit_p0 = (|(lz & an_hot_p0)) ? 7'h00 : font(nib_p0);
`else
  assign lit_p0 = font(nib_p0);
`endif

  // Stage p0: prescaler, digit index and shadow/pending handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p0     <= '0;
      idx_p0     <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_flag  <= 1'b0;
    end else begin
      cnt_p0 <= slot_end ? '0 : cnt_p0 + CNT_W'(1);
      if (slot_end)
        idx_p0 <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + IDX_W'(1);
      if (boundary && in_load) begin
        shadow_val <= in_value;
        shadow_dp  <= in_dp;
        pend_flag  <= 1'b0;
      end else if (boundary && pend_flag) begin
        shadow_val <= pend_val;
        shadow_dp  <= pend_dp;
        pend_flag  <= 1'b0;
      end else if (in_load) begin
        pend_val  <= in_value;
        pend_dp   <= in_dp;
        pend_flag <= 1'b1;
      end
    end
  end

  // Stage p1: registered pin drivers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_p1    <= {NUM_DIGITS{POL}};
      seg_p1   <= seg_pol(7'h00);
      dp_p1    <= POL;
      frame_p1 <= 1'b0;
    end else begin
      frame_p1 <= boundary;
      if (blank_p0) begin
        an_p1  <= {NUM_DIGITS{POL}};
        seg_p1 <= seg_pol(7'h00);
        dp_p1  <= POL;
      end else begin
        an_p1  <= POL ? ~an_hot_p0 : an_hot_p0;
        seg_p1 <= seg_pol(lit_p0);
        dp_p1  <= POL ^ dp_bit_p0;
      end
    end
  end

  assign out_seg   = seg_p1;
  assign out_dp    = dp_p1;
  assign out_an    = an_p1;
  assign out_frame = frame_p1;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed bench for sevenseg_scan with NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, ACTIVE_LOW=1.
module tb_sevenseg_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_value = '0;
  logic [3:0]  in_dp = '0;
  logic        in_load = 1'b0;
  logic [6:0]  out_seg;
  logic        out_dp;
  logic [3:0]  out_an;
  logic        out_frame;

  int vectors = 0;
  int miscompares = 0;

  sevenseg_scan #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_value(in_value), .in_dp(in_dp), .in_load(in_load),
    .out_seg(out_seg), .out_dp(out_dp), .out_an(out_an), .out_frame(out_frame)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] dp);
    in_value = v;
    in_dp    = dp;
    in_load  = 1'b1;
    tick();
    in_load  = 1'b0;
  endtask

  // Returns at the sample where out_frame is high; digit d is then visible 2+4d samples later.
  task automatic wait_frame(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      tick();
      if (out_frame === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: out_frame stayed %b, required a pulse within 64 cycles", name, out_frame);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (out_an !== 4'b1111 || out_seg !== 7'h7F || out_dp !== 1'b1 || out_frame !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: an=%b seg=%h dp=%b frame=%b, required 1111 7f 1 0",
               out_an, out_seg, out_dp, out_frame);
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if (out_an !== 4'b1111 || out_seg !== 7'h7F) begin
      miscompares++;
      $display("FAIL reset_first_blank: an=%b seg=%h, required 1111 7f", out_an, out_seg);
    end
    for (int c = 1; c < 4; c++) begin
      tick();
      vectors++;
      if (out_an !== 4'b1110 || out_seg !== 7'h40 || out_dp !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_digit0_c%0d: an=%b seg=%h dp=%b, required 1110 40 1",
                 c, out_an, out_seg, out_dp);
      end
    end
  endtask

  task automatic test_load_midframe();
    logic [6:0] exp_seg [4];
    logic [3:0] exp_an  [4];
    exp_seg = '{7'h0E, 7'h08, 7'h24, 7'h79};
    exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    wait_frame("midframe_sync");
    repeat (5) tick();
    load(16'h12AF, 4'b0000);
    repeat (4) tick();
    vectors++;
    if (out_an !== 4'b1011 || out_seg !== 7'h40) begin
      miscompares++;
      $display("FAIL midframe_no_tear: an=%b seg=%h, required 1011 40", out_an, out_seg);
    end
    wait_frame("midframe_boundary");
    tick();
    for (int d = 0; d < 4; d++) begin
      if (d == 0) tick(); else repeat (4) tick();
      vectors++;
      if (out_an !== exp_an[d] || out_seg !== exp_seg[d]) begin
        miscompares++;
        $display("FAIL midframe_digit%0d: an=%b seg=%h, required %b %h",
                 d, out_an, out_seg, exp_an[d], exp_seg[d]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_an [4];
    exp_an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    wait_frame("b2b_sync");
    repeat (3) tick();
    load(16'h1111, 4'b0000);
    repeat (3) tick();
    load(16'h2222, 4'b0000);
    wait_frame("b2b_boundary");
    tick();
    vectors++;
    if (out_frame !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_width: out_frame=%b one cycle after pulse, required 0", out_frame);
    end
    for (int d = 0; d < 4; d++) begin
      if (d == 0) tick(); else repeat (4) tick();
      vectors++;
      if (out_an !== exp_an[d] || out_seg !== 7'h24) begin
        miscompares++;
        $display("FAIL b2b_digit%0d: an=%b seg=%h, required %b 24", d, out_an, out_seg, exp_an[d]);
      end
    end
  endtask

  task automatic test_boundary_load();
    wait_frame("bnd_sync");
    repeat (15) tick();
    in_value = 16'h0005;
    in_dp    = 4'b0000;
    in_load  = 1'b1;
    tick();
    in_load  = 1'b0;
    vectors++;
    if (out_frame !== 1'b1) begin
      miscompares++;
      $display("FAIL bnd_frame: out_frame=%b on boundary, required 1", out_frame);
    end
    repeat (2) tick();
    vectors++;
    if (out_an !== 4'b1110 || out_seg !== 7'h12) begin
      miscompares++;
      $display("FAIL bnd_digit0: an=%b seg=%h, required 1110 12", out_an, out_seg);
    end
  endtask

  task automatic test_dp();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    int         c, d;
    wait_frame("dp_sync");
    repeat (4) tick();
    load(16'h0000, 4'b0100);
    wait_frame("dp_boundary");
    for (int j = 1; j <= 16; j++) begin
      tick();
      c = (j - 1) % 4;
      d = (j - 1) / 4;
      e_an  = (c == 0) ? 4'b1111 : ~(4'b0001 << d);
      e_seg = (c == 0) ? 7'h7F : 7'h40;
      e_dp  = (d == 2 && c != 0) ? 1'b0 : 1'b1;
      vectors++;
      if (out_an !== e_an || out_seg !== e_seg || out_dp !== e_dp) begin
        miscompares++;
        $display("FAIL dp_cycle%0d: an=%b seg=%h dp=%b, required %b %h %b",
                 j, out_an, out_seg, out_dp, e_an, e_seg, e_dp);
      end
    end
  endtask

  task automatic test_lzb();
    logic [6:0] exp_seg [4];
    logic [3:0] exp_an  [4];
`ifdef SEVENSEG_SCAN_LZB_EN
    exp_seg = '{7'h40, 7'h30, 7'h7F, 7'h7F};
`else
    exp_seg = '{7'h40, 7'h30, 7'h40, 7'h40};
`endif
    exp_an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    wait_frame("lzb_sync");
    repeat (4) tick();
    load(16'h0030, 4'b0000);
    wait_frame("lzb_boundary");
    tick();
    for (int d = 0; d < 4; d++) begin
      if (d == 0) tick(); else repeat (4) tick();
      vectors++;
      if (out_an !== exp_an[d] || out_seg !== exp_seg[d]) begin
        miscompares++;
        $display("FAIL lzb_digit%0d: an=%b seg=%h, required %b %h",
                 d, out_an, out_seg, exp_an[d], exp_seg[d]);
      end
    end
  endtask

  task automatic test_async_reset();
    wait_frame("rst_sync");
    repeat (2) tick();
    load(16'h0009, 4'b0001);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_an !== 4'b1111 || out_seg !== 7'h7F || out_dp !== 1'b1 || out_frame !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: an=%b seg=%h dp=%b frame=%b, required 1111 7f 1 0",
               out_an, out_seg, out_dp, out_frame);
    end
    tick();
    rst_n = 1'b1;
    wait_frame("rst_boundary");
    repeat (2) tick();
    vectors++;
    if (out_an !== 4'b1110 || out_seg !== 7'h40 || out_dp !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_discards_pending: an=%b seg=%h dp=%b, required 1110 40 1",
               out_an, out_seg, out_dp);
    end
  endtask

  initial begin
    test_reset();
    test_load_midframe();
    test_back_to_back();
    test_boundary_load();
    test_dp();
    test_lzb();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
